// File: rtl/click_rr_arb_if.sv
// Handshake bundle between the round-robin arbiter, its requesters and the downstream click buffer.
// master is the arbiter side; slave is the environment (requesters plus downstream stage).
interface click_rr_arb_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 2,
   parameter int unsigned IW   = 2
);
   logic [NREQ-1:0]    in_req;
   logic [NREQ-1:0]    in_ack;
   logic [NREQ*DW-1:0] in_data;
   logic               out_req;
   logic               out_ack;
   logic [DW-1:0]      out_data;
   logic [IW-1:0]      grant_id;
   logic               busy;
   logic [7:0]         xfer_cnt;
   logic               err;

   modport master (
      input  in_req, in_data, out_ack,
      output in_ack, out_req, out_data, grant_id, busy, xfer_cnt, err
   );

   modport slave (
      output in_req, in_data, out_ack,
      input  in_ack, out_req, out_data, grant_id, busy, xfer_cnt, err
   );
endinterface

// File: rtl/click_rr_arb.sv
// Round-robin arbiter serialising NREQ two-phase requesters onto one two-phase downstream channel.
// A grant toggles out_req; the matching out_ack toggles the winner's in_ack and advances the pointer.
module click_rr_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned DW   = 2,
   parameter int unsigned IW   = 2
) (
   input  logic           clk,
   input  logic           reset,
   click_rr_arb_if.master bus
);
   localparam int unsigned CW = 8;

   typedef enum logic {IDLE, WAIT} state_e;

   state_e            state_q, state_d;
   logic [NREQ-1:0]   in_ack_q, in_ack_d;
   logic              out_req_q, out_req_d;
   logic [DW-1:0]     out_data_q, out_data_d;
   logic [IW-1:0]     grant_q, grant_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic [CW-1:0]     xfer_cnt_q, xfer_cnt_d;
   logic              err_q, err_d;

   logic [NREQ-1:0]   pending;
   logic [DW-1:0]     data_arr [NREQ];
   logic              found;
   logic [IW-1:0]     win;
   logic [IW-1:0]     grant_nxt;

   assign pending = bus.in_req ^ in_ack_q;

   always_comb begin : unpack_data
      for (int i = 0; i < int'(NREQ); i++) begin
         data_arr[i] = bus.in_data[i*DW +: DW];
      end
   end

   // First pending channel scanning upward from ptr, wrapping at NREQ-1.
   always_comb begin : rr_pick
      int unsigned idx;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && pending[IW'(idx)]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
   end

   assign grant_nxt = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

   always_comb begin : fsm_next
      state_d    = state_q;
      in_ack_d   = in_ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      grant_d    = grant_q;
      ptr_d      = ptr_q;
      xfer_cnt_d = xfer_cnt_q;
      err_d      = err_q;

      case (state_q)
         IDLE: begin
            // A downstream ack with no outstanding request is a protocol error.
            if (bus.out_ack != out_req_q) begin
               err_d = 1'b1;
            end
            if (found) begin
               out_data_d = data_arr[win];
               grant_d    = win;
               out_req_d  = ~out_req_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (bus.out_ack == out_req_q) begin
               in_ack_d[grant_q] = ~in_ack_q[grant_q];
               ptr_d             = grant_nxt;
               xfer_cnt_d        = xfer_cnt_q + 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == WAIT);
   end

   always_ff @(posedge clk) begin : regs
      if (reset) begin
         state_q    <= IDLE;
         in_ack_q   <= '0;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
         grant_q    <= '0;
         ptr_q      <= '0;
         busy_q     <= 1'b0;
         xfer_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ack_q   <= in_ack_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
         grant_q    <= grant_d;
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         xfer_cnt_q <= xfer_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ack   = in_ack_q;
   assign bus.out_req  = out_req_q;
   assign bus.out_data = out_data_q;
   assign bus.grant_id = grant_q;
   assign bus.busy     = busy_q;
   assign bus.xfer_cnt = xfer_cnt_q;
   assign bus.err      = err_q;
endmodule

// File: tb/tb_click_rr_arb.sv
// Bench for click_rr_arb: table of single transfers, scoreboarded bursts, and hand-written
// sequences for fairness, downstream stall, spurious ack and reset during a transfer.
module tb_click_rr_arb;
   localparam int unsigned NREQ = 4;
   localparam int unsigned DW   = 2;
   localparam int unsigned IW   = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   click_rr_arb_if #(.NREQ(NREQ), .DW(DW), .IW(IW)) bus ();

   click_rr_arb #(.NREQ(NREQ), .DW(DW), .IW(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            ch;
      logic [DW-1:0] data;
      int            exp_grant;
      logic [DW-1:0] exp_data;
      int            exp_xfer;
   } vec_t;

   typedef struct {
      int            id;
      logic [DW-1:0] data;
   } exp_t;

   int              checks = 0;
   int              errors = 0;
   logic [NREQ-1:0] m_ack;
   logic            m_out_req;
   int              m_ptr;
   exp_t            sb[$];
   vec_t            vecs[4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      bus.in_req  = '0;
      bus.in_data = '0;
      bus.out_ack = 1'b0;
      step();
      reset     = 1'b0;
      m_ack     = '0;
      m_out_req = 1'b0;
      m_ptr     = 0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_req"},  bus.out_req,  0);
      check({tag, "_in_ack"},   bus.in_ack,   0);
      check({tag, "_out_data"}, bus.out_data, 0);
      check({tag, "_grant"},    bus.grant_id, 0);
      check({tag, "_busy"},     bus.busy,     0);
      check({tag, "_xfer"},     bus.xfer_cnt, 0);
      check({tag, "_err"},      bus.err,      0);
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] pend, input int ptr);
      int c;
      for (int k = 0; k < int'(NREQ); k++) begin
         c = (ptr + k) % int'(NREQ);
         if (pend[IW'(c)]) return c;
      end
      return -1;
   endfunction

   // One isolated transfer: request, grant check, immediate ack, completion check.
   task automatic apply_vec(input vec_t v);
      bus.in_data[v.ch*DW +: DW] = v.data;
      bus.in_req[v.ch]           = ~bus.in_req[v.ch];
      step();
      m_out_req = ~m_out_req;
      check("vec_out_req",  bus.out_req,  m_out_req);
      check("vec_grant",    bus.grant_id, v.exp_grant);
      check("vec_out_data", bus.out_data, v.exp_data);
      check("vec_busy_w",   bus.busy,     1);
      bus.out_ack = m_out_req;
      step();
      m_ack[v.ch] = ~m_ack[v.ch];
      check("vec_in_ack",   bus.in_ack,   m_ack);
      check("vec_xfer",     bus.xfer_cnt, v.exp_xfer);
      check("vec_busy_i",   bus.busy,     0);
      m_ptr = (v.exp_grant + 1) % int'(NREQ);
   endtask

   // Toggle several requests at once; expected grants queued in model order, checked as they appear.
   task automatic burst(input logic [NREQ-1:0] mask);
      logic [NREQ-1:0] pend;
      int              g;
      int              cyc;
      bit              ack_due;
      exp_t            e;
      pend = mask;
      while (pend != '0) begin
         g      = rr_pick(pend, m_ptr);
         e.id   = g;
         e.data = bus.in_data[g*DW +: DW];
         sb.push_back(e);
         pend[g]  = 1'b0;
         m_ack[g] = ~m_ack[g];
         m_ptr    = (g + 1) % int'(NREQ);
      end
      bus.in_req = bus.in_req ^ mask;
      cyc     = 0;
      ack_due = 1'b0;
      while ((sb.size() != 0 || bus.busy || ack_due) && cyc < 200) begin
         step();
         cyc++;
         if (ack_due) begin
            bus.out_ack = m_out_req;
            ack_due     = 1'b0;
         end else if (bus.out_req !== m_out_req) begin
            m_out_req = bus.out_req;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_extra: unexpected grant to %0d", bus.grant_id);
            end else begin
               e = sb.pop_front();
               check("sb_grant", bus.grant_id, e.id);
               check("sb_data",  bus.out_data, e.data);
            end
            ack_due = 1'b1;
         end
      end
      if (cyc >= 200) begin
         checks++;
         errors++;
         $display("FAIL sb_timeout: %0d grants outstanding", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      vecs[0] = '{2, 2'b10, 2, 2'b10, 1};
      vecs[1] = '{0, 2'b01, 0, 2'b01, 2};
      vecs[2] = '{3, 2'b11, 3, 2'b11, 3};
      vecs[3] = '{1, 2'b00, 1, 2'b00, 4};

      bus.in_req  = '0;
      bus.in_data = '0;
      bus.out_ack = 1'b0;
      do_reset();
      check_reset_state("rst");

      for (int i = 0; i < 4; i++) apply_vec(vecs[i]);

      // All four at once from reset: grants 0,1,2,3.
      do_reset();
      bus.in_data = 8'b11_10_01_00;
      burst(4'b1111);
      check("burst_xfer",   bus.xfer_cnt, 4);
      check("burst_in_ack", bus.in_ack,   4'b1111);

      // ptr=1 after granting 0; with 0 and 3 pending, 3 must win first.
      apply_vec('{0, 2'b01, 0, 2'b01, 5});
      bus.in_data[0*DW +: DW] = 2'b00;
      bus.in_data[3*DW +: DW] = 2'b10;
      bus.in_req[0] = ~bus.in_req[0];
      bus.in_req[3] = ~bus.in_req[3];
      step();
      m_out_req = ~m_out_req;
      check("fair_first",  bus.grant_id, 3);
      check("fair_data1",  bus.out_data, 2'b10);
      bus.out_ack = m_out_req;
      step();
      m_ack[3] = ~m_ack[3];
      check("fair_ack3",   bus.in_ack, m_ack);
      step();
      m_out_req = ~m_out_req;
      check("fair_req2",   bus.out_req,  m_out_req);
      check("fair_second", bus.grant_id, 0);
      check("fair_data2",  bus.out_data, 2'b00);
      bus.out_ack = m_out_req;
      step();
      m_ack[0] = ~m_ack[0];
      check("fair_ack0",   bus.in_ack,   m_ack);
      check("fair_xfer",   bus.xfer_cnt, 7);

      // Downstream stall with channel 2 arriving meanwhile.
      bus.in_data[1*DW +: DW] = 2'b01;
      bus.in_req[1] = ~bus.in_req[1];
      step();
      m_out_req = ~m_out_req;
      check("stall_req",   bus.out_req,  m_out_req);
      check("stall_grant", bus.grant_id, 1);
      bus.in_data[2*DW +: DW] = 2'b11;
      bus.in_req[2] = ~bus.in_req[2];
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_busy",  bus.busy,     1);
         check("stall_oreq",  bus.out_req,  m_out_req);
         check("stall_odata", bus.out_data, 2'b01);
         check("stall_gid",   bus.grant_id, 1);
         check("stall_iack",  bus.in_ack,   m_ack);
      end
      bus.out_ack = m_out_req;
      step();
      m_ack[1] = ~m_ack[1];
      check("stall_done_ack",  bus.in_ack,   m_ack);
      check("stall_done_busy", bus.busy,     0);
      check("stall_done_xfer", bus.xfer_cnt, 8);
      step();
      m_out_req = ~m_out_req;
      check("stall_next_req",   bus.out_req,  m_out_req);
      check("stall_next_grant", bus.grant_id, 2);
      check("stall_next_data",  bus.out_data, 2'b11);
      bus.out_ack = m_out_req;
      step();
      m_ack[2] = ~m_ack[2];
      check("stall_next_ack",  bus.in_ack,   m_ack);
      check("stall_next_xfer", bus.xfer_cnt, 9);

      // Spurious downstream ack in IDLE.
      do_reset();
      bus.out_ack = 1'b1;
      step();
      check("spur_err",  bus.err,     1);
      check("spur_busy", bus.busy,    0);
      check("spur_oreq", bus.out_req, 0);
      step();
      check("spur_sticky", bus.err, 1);
      bus.in_data[1*DW +: DW] = 2'b10;
      bus.in_req[1] = 1'b1;
      step();
      m_out_req = 1'b1;
      check("spur_grant_req",  bus.out_req,  1);
      check("spur_grant_id",   bus.grant_id, 1);
      check("spur_grant_data", bus.out_data, 2'b10);
      check("spur_grant_busy", bus.busy,     1);
      step();
      m_ack[1] = 1'b1;
      check("spur_in_ack", bus.in_ack,   4'b0010);
      check("spur_xfer",   bus.xfer_cnt, 1);
      check("spur_err2",   bus.err,      1);

      // Channel 0 completes, then reset lands while channel 3 is in flight.
      bus.in_req[0] = 1'b1;
      step();
      m_out_req = 1'b0;
      check("mid_g0", bus.grant_id, 0);
      bus.out_ack = 1'b0;
      step();
      check("mid_ack0", bus.in_ack, 4'b0011);
      bus.in_data[3*DW +: DW] = 2'b11;
      bus.in_req[3] = 1'b1;
      step();
      check("mid_busy",  bus.busy,     1);
      check("mid_oreq",  bus.out_req,  1);
      check("mid_grant", bus.grant_id, 3);
      do_reset();
      check_reset_state("midrst");
      step();
      check("post_rst_busy", bus.busy,    0);
      check("post_rst_oreq", bus.out_req, 0);

      // Pointer restarts at 0 after reset.
      bus.in_data = 8'b00_00_11_01;
      burst(4'b0011);
      check("post_rst_xfer", bus.xfer_cnt, 2);
      check("post_rst_iack", bus.in_ack,   4'b0011);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
